// File: rtl/fox_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : fox_packet_assembler
//  Purpose  : PE message-out side of a Fox node. Latches field strobes, builds
//             a packet on packet_complete_in, queues it in a small FIFO and
//             offers it to the Hoplite router with valid/ready handshaking.
//  Options  : FOX_ASSEMBLER_STRICT_CHECK_EN enables the missing-field checker.
//  Revision : 1.0  initial release
// ============================================================================
module fox_packet_assembler #(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int FIFO_DEPTH           = 4,
    localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                 MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                 MATRIX_ELEMENT_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,

    input  logic [COORD_BITS-1:0]           x_coord_in,
    input  logic                            x_coord_in_valid,
    input  logic [COORD_BITS-1:0]           y_coord_in,
    input  logic                            y_coord_in_valid,
    input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
    input  logic                            multicast_group_in_valid,
    input  logic                            ready_flag_in,
    input  logic                            ready_flag_in_valid,
    input  logic                            result_flag_in,
    input  logic                            result_flag_in_valid,
    input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
    input  logic                            matrix_type_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
    input  logic                            matrix_x_coord_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
    input  logic                            matrix_y_coord_in_valid,
    input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
    input  logic                            matrix_element_in_valid,
    input  logic                            packet_complete_in,

    output logic                            message_out_ready,
    output logic [PACKET_BITS-1:0]          packet_out,
    output logic                            packet_out_valid,
    input  logic                            packet_out_ready,
    output logic                            overflow,
    output logic                            missing_field_err
);

    localparam int c_ptr_bits = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_bits:0] c_full_count = (c_ptr_bits+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Sticky field registers
    // ------------------------------------------------------------------
    logic [COORD_BITS-1:0]           r_x_coord;
    logic [COORD_BITS-1:0]           r_y_coord;
    logic [MULTICAST_GROUP_BITS-1:0] r_multicast_group;
    logic                            r_ready_flag;
    logic                            r_result_flag;
    logic [MATRIX_TYPE_BITS-1:0]     r_matrix_type;
    logic [MATRIX_COORD_BITS-1:0]    r_matrix_x_coord;
    logic [MATRIX_COORD_BITS-1:0]    r_matrix_y_coord;
    logic [MATRIX_ELEMENT_BITS-1:0]  r_matrix_element;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x_coord         <= '0;
            r_y_coord         <= '0;
            r_multicast_group <= '0;
            r_ready_flag      <= 1'b0;
            r_result_flag     <= 1'b0;
            r_matrix_type     <= '0;
            r_matrix_x_coord  <= '0;
            r_matrix_y_coord  <= '0;
            r_matrix_element  <= '0;
        end else begin
            if (x_coord_in_valid)         r_x_coord         <= x_coord_in;
            if (y_coord_in_valid)         r_y_coord         <= y_coord_in;
            if (multicast_group_in_valid) r_multicast_group <= multicast_group_in;
            if (ready_flag_in_valid)      r_ready_flag      <= ready_flag_in;
            if (result_flag_in_valid)     r_result_flag     <= result_flag_in;
            if (matrix_type_in_valid)     r_matrix_type     <= matrix_type_in;
            if (matrix_x_coord_in_valid)  r_matrix_x_coord  <= matrix_x_coord_in;
            if (matrix_y_coord_in_valid)  r_matrix_y_coord  <= matrix_y_coord_in;
            if (matrix_element_in_valid)  r_matrix_element  <= matrix_element_in;
        end
    end

    // Packet is built from the pre-edge register values, so a strobe in the
    // same cycle as a complete only affects the following packet.
    logic [PACKET_BITS-1:0] w_packet;
    assign w_packet = {r_x_coord, r_y_coord, r_multicast_group, r_ready_flag,
                       r_result_flag, r_matrix_type, r_matrix_x_coord,
                       r_matrix_y_coord, r_matrix_element};

    // ------------------------------------------------------------------
    // Packet FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [PACKET_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_bits-1:0]  r_wr_ptr;
    logic [c_ptr_bits-1:0]  r_rd_ptr;
    logic [c_ptr_bits:0]    r_count;
    logic                   r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == c_full_count);
    assign w_pop   = packet_out_valid && packet_out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = packet_complete_in && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_packet;
                r_wr_ptr        <= r_wr_ptr + c_ptr_bits'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_bits'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_bits+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_bits+1)'(1);
                default: r_count <= r_count;
            endcase
            if (packet_complete_in && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign packet_out_valid  = (r_count != '0);
    assign packet_out        = r_mem[r_rd_ptr];
    assign message_out_ready = !w_full;
    assign overflow          = r_overflow;

    // ------------------------------------------------------------------
    // Optional missing-field checker (x, y and element must be rewritten
    // between consecutive completes)
    // ------------------------------------------------------------------
`ifdef FOX_ASSEMBLER_STRICT_CHECK_EN
    logic [2:0] r_written;
    logic [2:0] w_strobes;
    logic       r_missing_field_err;

    assign w_strobes = {x_coord_in_valid, y_coord_in_valid, matrix_element_in_valid};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_written           <= 3'b000;
            r_missing_field_err <= 1'b0;
        end else if (packet_complete_in) begin
            if (r_written != 3'b111) begin
                r_missing_field_err <= 1'b1;
            end
            r_written <= w_strobes;
        end else begin
            r_written <= r_written | w_strobes;
        end
    end

    assign missing_field_err = r_missing_field_err;
`else
    assign missing_field_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fox_packet_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fox_packet_assembler
//  Purpose  : Directed self-checking bench for fox_packet_assembler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fox_packet_assembler;

`ifdef FOX_ASSEMBLER_STRICT_CHECK_EN
    localparam logic EXP_STRICT = 1'b1;
`else
    localparam logic EXP_STRICT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        x_in, x_v, y_in, y_v, mg_in, mg_v, rf_in, rf_v, res_in, res_v, mt_in, mt_v;
    logic [7:0]  mx_in, my_in;
    logic        mx_v, my_v;
    logic [31:0] el_in;
    logic        el_v;
    logic        complete;
    logic        msg_ready;
    logic [53:0] pkt;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // shadow copy of the field registers
    logic        s_x, s_y, s_mg, s_rf, s_res, s_mt;
    logic [7:0]  s_mx, s_my;
    logic [31:0] s_el;

    logic [53:0] expq [$];

    fox_packet_assembler dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .x_coord_in              (x_in),
        .x_coord_in_valid        (x_v),
        .y_coord_in              (y_in),
        .y_coord_in_valid        (y_v),
        .multicast_group_in      (mg_in),
        .multicast_group_in_valid(mg_v),
        .ready_flag_in           (rf_in),
        .ready_flag_in_valid     (rf_v),
        .result_flag_in          (res_in),
        .result_flag_in_valid    (res_v),
        .matrix_type_in          (mt_in),
        .matrix_type_in_valid    (mt_v),
        .matrix_x_coord_in       (mx_in),
        .matrix_x_coord_in_valid (mx_v),
        .matrix_y_coord_in       (my_in),
        .matrix_y_coord_in_valid (my_v),
        .matrix_element_in       (el_in),
        .matrix_element_in_valid (el_v),
        .packet_complete_in      (complete),
        .message_out_ready       (msg_ready),
        .packet_out              (pkt),
        .packet_out_valid        (pkt_valid),
        .packet_out_ready        (pkt_ready),
        .overflow                (ovf),
        .missing_field_err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [53:0] pack();
        return {s_x, s_y, s_mg, s_rf, s_res, s_mt, s_mx, s_my, s_el};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        {s_x, s_y, s_mg, s_rf, s_res, s_mt} = '0;
        s_mx = '0; s_my = '0; s_el = '0;
    endtask

    task automatic set_fields(input logic x, input logic y, input logic mg, input logic rf,
                              input logic res, input logic mt, input logic [7:0] mx,
                              input logic [7:0] my, input logic [31:0] el);
        x_in = x; y_in = y; mg_in = mg; rf_in = rf; res_in = res; mt_in = mt;
        mx_in = mx; my_in = my; el_in = el;
        {x_v, y_v, mg_v, rf_v, res_v, mt_v, mx_v, my_v, el_v} = '1;
        step();
        {x_v, y_v, mg_v, rf_v, res_v, mt_v, mx_v, my_v, el_v} = '0;
        s_x = x; s_y = y; s_mg = mg; s_rf = rf; s_res = res; s_mt = mt;
        s_mx = mx; s_my = my; s_el = el;
    endtask

    task automatic wr_elem(input logic [31:0] el);
        el_in = el;
        el_v  = 1'b1;
        step();
        el_v  = 1'b0;
        s_el  = el;
    endtask

    task automatic do_complete();
        complete = 1'b1;
        step();
        complete = 1'b0;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [53:0] prev;
        logic        stalled;
        int          cyc;

        reset_n = 1'b0;
        {x_in, x_v, y_in, y_v, mg_in, mg_v, rf_in, rf_v, res_in, res_v, mt_in, mt_v} = '0;
        mx_in = '0; my_in = '0; mx_v = 1'b0; my_v = 1'b0;
        el_in = '0; el_v = 1'b0;
        complete = 1'b0;
        pkt_ready = 1'b0;
        step();
        do_reset();

        check_val("reset_valid", pkt_valid, 0);
        check_val("reset_msg_ready", msg_ready, 1);
        check_val("reset_overflow", ovf, 0);
        check_val("reset_err", err, 0);
        check_val("reset_packet", pkt, 0);

        // single packet
        pkt_ready = 1'b1;
        set_fields(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 32'hDEAD_BEEF);
        do_complete();
        check_val("single_valid", pkt_valid, 1);
        check_val("single_packet", pkt, 54'h20_0000_DEAD_BEEF);
        check_val("single_err", err, 0);
        check_val("single_msg_ready", msg_ready, 1);
        step();
        check_val("single_valid_drop", pkt_valid, 0);
        check_val("single_msg_ready2", msg_ready, 1);

        // fill and overflow
        pkt_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wr_elem(32'(i));
            do_complete();
            if (i == 3) check_val("fill_msg_ready_3", msg_ready, 1);
        end
        check_val("fill_msg_ready_full", msg_ready, 0);
        check_val("fill_overflow_pre", ovf, 0);
        wr_elem(32'd5);
        do_complete();
        check_val("fill_overflow", ovf, 1);
        check_val("fill_msg_ready_still", msg_ready, 0);
        pkt_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_val("fill_pop_order", pkt[31:0], 32'(i));
            step();
            if (i == 1) check_val("fill_msg_ready_after_pop", msg_ready, 1);
        end
        check_val("fill_empty", pkt_valid, 0);
        check_val("fill_overflow_sticky", ovf, 1);

        // full with simultaneous push and pop
        do_reset();
        pkt_ready = 1'b0;
        for (int i = 10; i <= 13; i++) begin
            wr_elem(32'(i));
            do_complete();
        end
        wr_elem(32'd14);
        complete  = 1'b1;
        pkt_ready = 1'b1;
        step();
        complete  = 1'b0;
        check_val("pp_msg_ready", msg_ready, 0);
        check_val("pp_overflow", ovf, 0);
        for (int i = 11; i <= 14; i++) begin
            check_val("pp_order", pkt[31:0], 32'(i));
            step();
        end
        check_val("pp_empty", pkt_valid, 0);

        // sticky fields and strobe coincident with complete
        pkt_ready = 1'b0;
        wr_elem(32'd7);
        do_complete();
        el_in = 32'd9; el_v = 1'b1; complete = 1'b1;
        step();
        el_v = 1'b0; complete = 1'b0;
        do_complete();
        pkt_ready = 1'b1;
        check_val("sticky_pkt1", pkt[31:0], 7);
        step();
        check_val("sticky_pkt2", pkt[31:0], 7);
        step();
        check_val("sticky_pkt3", pkt[31:0], 9);
        step();
        check_val("sticky_empty", pkt_valid, 0);

        // backpressure: two batches of four, fixed ready pattern
        pat = 8'b1001_0110;
        for (int b = 0; b < 2; b++) begin
            pkt_ready = 1'b0;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = b*4 + i;
                set_fields(k[0], k[1], 1'b0, k[2], 1'b1, 1'b0, 8'(k), 8'(k*3), 32'(100+k));
                expq.push_back(pack());
                do_complete();
            end
            stalled = 1'b0;
            prev    = '0;
            cyc     = 0;
            while (expq.size() != 0 && cyc < 64) begin
                pkt_ready = pat[cyc % 8];
                if (pkt_valid) begin
                    if (stalled) check_val("bp_stable", pkt, prev);
                    if (pkt_ready) check_val("bp_order", pkt, expq.pop_front());
                end
                stalled = pkt_valid && !pkt_ready;
                prev    = pkt;
                cyc++;
                step();
            end
            check_val("bp_drained", 32'(expq.size()), 0);
            check_val("bp_no_dup", pkt_valid, 0);
            expq.delete();
        end

        // reset with packets queued
        pkt_ready = 1'b0;
        wr_elem(32'd55);
        do_complete();
        do_complete();
        check_val("rst_queued_valid", pkt_valid, 1);
        reset_n = 1'b0;
        step();
        check_val("rst_valid", pkt_valid, 0);
        check_val("rst_packet", pkt, 0);
        check_val("rst_msg_ready", msg_ready, 1);
        reset_n = 1'b1;
        step();
        check_val("rst_valid_after", pkt_valid, 0);
        do_complete();
        check_val("rst_fields_zero_valid", pkt_valid, 1);
        check_val("rst_fields_zero", pkt, 0);
        pkt_ready = 1'b1;
        step();
        check_val("rst_pop", pkt_valid, 0);

        // strict check: only element written
        do_reset();
        pkt_ready = 1'b0;
        wr_elem(32'd5);
        do_complete();
        check_val("strict_err", err, EXP_STRICT);
        check_val("strict_valid", pkt_valid, 1);
        check_val("strict_packet", pkt, 54'd5);
        pkt_ready = 1'b1;
        step();
        check_val("strict_popped", pkt_valid, 0);
        check_val("strict_err_sticky", err, EXP_STRICT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
